// File: rtl/batcharger_ctrl_mc.sv
`timescale 1ns/1ps
// batcharger_ctrl_mc
//   Multi-channel battery charge controller. Each channel runs an independent
//   IDLE/TC/CC/CV/DONE/FAULT state machine driven by ADC codes for battery
//   voltage, current and temperature, plus a per-channel tick timer that is
//   clocked from one shared prescaler.
//
// Ports
//   clk, rstz          system clock (rising edge) and async active-low reset
//   en[NCH]            per-channel charge enable
//   vbat/ibat/tbat     per-channel ADC codes, channel i at [i*W +: W]
//   vcutoff, vtarget   TC->CC and CC->CV voltage thresholds (shared)
//   vpreset            recharge threshold while in DONE (shared)
//   iend               CV end-of-charge current (shared)
//   tmin, tmax         inclusive temperature window (shared)
//   tlimit             per-state charge timeout in ticks, 0 disables
//   tc, cc, cv, pwr_en mode enables to the power stage
//   state[NCH*3]       per-channel state code
//   done, fault        per-channel status flags
module batcharger_ctrl_mc #(
  parameter int NCH   = 2,
  parameter int W     = 8,
  parameter int TW    = 8,
  parameter int PRESC = 4
) (
  input  logic               clk,
  input  logic               rstz,
  input  logic [NCH-1:0]     en,
  input  logic [NCH*W-1:0]   vbat,
  input  logic [NCH*W-1:0]   ibat,
  input  logic [NCH*W-1:0]   tbat,
  input  logic [W-1:0]       vcutoff,
  input  logic [W-1:0]       vtarget,
  input  logic [W-1:0]       vpreset,
  input  logic [W-1:0]       iend,
  input  logic [W-1:0]       tmin,
  input  logic [W-1:0]       tmax,
  input  logic [TW-1:0]      tlimit,
  output logic [NCH-1:0]     tc,
  output logic [NCH-1:0]     cc,
  output logic [NCH-1:0]     cv,
  output logic [NCH-1:0]     pwr_en,
  output logic [NCH*3-1:0]   state,
  output logic [NCH-1:0]     done,
  output logic [NCH-1:0]     fault
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TC    = 3'd1,
    S_CC    = 3'd2,
    S_CV    = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  state_e        st_q  [NCH];
  state_e        st_d  [NCH];
  logic [TW-1:0] cnt_q [NCH];
  logic [TW-1:0] cnt_d [NCH];

  // Charging state chosen purely from the present battery voltage.
  function automatic state_e entry_of(input logic [W-1:0] v,
                                      input logic [W-1:0] vcut,
                                      input logic [W-1:0] vtgt);
    if (v < vcut)      return S_TC;
    else if (v < vtgt) return S_CC;
    else               return S_CV;
  endfunction

  always_comb begin
    tick    = (presc_q == PW'(PRESC - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  always_comb begin
    logic [W-1:0] v, ib, tb;
    logic         tok, tmo;
    state_e       ent;
    for (int unsigned i = 0; i < NCH; i++) begin
      v   = vbat[i*W +: W];
      ib  = ibat[i*W +: W];
      tb  = tbat[i*W +: W];
      tok = (tb >= tmin) && (tb <= tmax);
      tmo = (tlimit != '0) && (cnt_q[i] >= tlimit);
      ent = entry_of(v, vcutoff, vtarget);

      st_d[i] = st_q[i];
      if (!en[i]) begin
        st_d[i] = S_IDLE;
      end else begin
        case (st_q[i])
          S_IDLE:  st_d[i] = tok ? ent : S_FAULT;
          // Timeout outranks the threshold crossing in TC/CC.
          S_TC:    if (!tok || tmo)        st_d[i] = S_FAULT;
                   else if (v >= vcutoff)  st_d[i] = S_CC;
          S_CC:    if (!tok || tmo)        st_d[i] = S_FAULT;
                   else if (v >= vtarget)  st_d[i] = S_CV;
          // In CV a timeout is a normal end of charge.
          S_CV:    if (!tok)               st_d[i] = S_FAULT;
                   else if (tmo || ib <= iend) st_d[i] = S_DONE;
          S_DONE:  if (v < vpreset && tok) st_d[i] = ent;
          S_FAULT: st_d[i] = S_FAULT;
          default: st_d[i] = S_IDLE;
        endcase
      end

      // A state change clears the timer even on a tick edge.
      if (st_d[i] != st_q[i])
        cnt_d[i] = '0;
      else if (tick && (cnt_q[i] != '1))
        cnt_d[i] = cnt_q[i] + TW'(1);
      else
        cnt_d[i] = cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      presc_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        st_q[i]  <= S_IDLE;
        cnt_q[i] <= '0;
      end
    end else begin
      presc_q <= presc_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Moore decode from the registered state; reset clears the state
  // asynchronously, so the mode outputs fall with it.
  always_comb begin
    tc     = '0;
    cc     = '0;
    cv     = '0;
    pwr_en = '0;
    done   = '0;
    fault  = '0;
    state  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      tc[i]          = (st_q[i] == S_TC);
      cc[i]          = (st_q[i] == S_CC);
      cv[i]          = (st_q[i] == S_CV);
      pwr_en[i]      = (st_q[i] == S_TC) || (st_q[i] == S_CC) || (st_q[i] == S_CV);
      done[i]        = (st_q[i] == S_DONE);
      fault[i]       = (st_q[i] == S_FAULT);
      state[i*3 +: 3] = st_q[i];
    end
  end

endmodule

// File: doc/batcharger_ctrl_mc.md
# batcharger_ctrl_mc

Multi-channel digital charge controller that drives the `en`/`tc`/`cc`/`cv` mode inputs of one or more battery charger power blocks. Each channel runs its own charging state machine: trickle, constant current, constant voltage, done, and fault. Transitions are decided from ADC-sampled battery voltage, current and temperature codes, plus a per-channel charge timer. The block sits between the ADC/config registers and the analog power stage. Channel count and ADC width are parameters.

## Interface
- `NCH`, 2, number of independent charger channels (1..8)
- `W`, 8, ADC code width for vbat/ibat/tbat and all thresholds
- `TW`, 8, timer width in ticks
- `PRESC`, 4, clock cycles per timer tick (>=1)

- `clk`  in  1  system clock, rising edge
- `rstz`  in  1  asynchronous active-low reset
- `en`  in  NCH  per-channel charge enable
- `vbat`  in  NCH*W  battery voltage code, channel i at [i*W +: W]
- `ibat`  in  NCH*W  battery current code, same packing
- `tbat`  in  NCH*W  battery temperature code, same packing
- `vcutoff`  in  W  TC→CC threshold (shared)
- `vtarget`  in  W  CC→CV threshold (shared)
- `vpreset`  in  W  recharge threshold from DONE (shared)
- `iend`  in  W  CV end-of-charge current (shared)
- `tmin`, `tmax`  in  W each  allowed temperature window, inclusive
- `tlimit`  in  TW  charge timer limit in ticks; 0 disables timeout
- `tc`, `cc`, `cv`  out  NCH each  mode enables to the power stage
- `pwr_en`  out  NCH  power stage enable
- `state`  out  NCH*3  per-channel state code
- `done`, `fault`  out  NCH each  status flags

## Operation
- State codes: IDLE=0, TC=1, CC=2, CV=3, DONE=4, FAULT=5. Codes 6 and 7 are illegal and go to IDLE on the next edge.
- Outputs are Moore outputs, decoded from the registered state:
  - `tc`=(TC), `cc`=(CC), `cv`=(CV), `pwr_en`=(TC|CC|CV).
  - `done`=(DONE), `fault`=(FAULT).
  - The mode outputs are one-hot or all zero.
- `tok` = (tmin ≤ tbat ≤ tmax).
- `entry` selects the charging state from vbat: vbat<vcutoff → TC; vcutoff≤vbat<vtarget → CC; vbat≥vtarget → CV.
- Transition priority per channel, highest first:
  1. `en`=0 → IDLE, from any state, including FAULT.
  2. In TC/CC/CV, `tok`=0 → FAULT.
  3. The state-specific rule below.
- State-specific rules:
  - IDLE: `en`=1 and `tok` → entry; `en`=1 and !`tok` → FAULT.
  - TC: vbat≥vcutoff → CC; timeout → FAULT.
  - CC: vbat≥vtarget → CV; timeout → FAULT.
  - CV: ibat≤iend → DONE; timeout → DONE (normal termination).
  - DONE: vbat<vpreset and `tok` → entry.
  - FAULT: held until `en`=0.
- All comparisons are unsigned, W bits.
- Timer:
  - Shared prescaler counts 0..PRESC-1 and emits `tick` when it is at PRESC-1.
  - Each channel has its own TW-bit tick counter. It clears on every state change and otherwise increments on `tick`, saturating at all-ones.
  - The counter runs in all states but only matters in TC/CC/CV.
  - timeout = (tlimit≠0) and (count ≥ tlimit).
  - The TC→CC transition clears the counter, so CC gets a fresh `tlimit`.
- Channels are fully independent. Shared thresholds apply to all channels.

## Timing
- Reset (`rstz`=0, asynchronous): all states = IDLE, all timers = 0, prescaler = 0.
  - All outputs are 0 during reset and immediately after.
  - `state` = 0 for all channels.
- Inputs are sampled at the rising edge. A qualifying condition at edge k changes `state` and the outputs after edge k, i.e. 1-cycle latency.
- Only one transition per channel per edge. Example: IDLE with vbat≥vtarget goes directly to CV (entry), not via TC/CC.
- A simultaneous timeout and threshold crossing in TC/CC resolves to FAULT; in CV it resolves to DONE.
- `tick` and a state change on the same edge: the counter clears (clear wins).
- Counter for a state entered at edge k: count=0 after edge k; count=n after the n-th tick following edge k.
- Reset asserted mid-charge: the mode outputs drop asynchronously, with no one-cycle overlap.
- Threshold inputs may change at any time; they take effect at the next edge.

## Test plan
- Setup for all scenarios: NCH=2, W=8, PRESC=4, TW=8.
- Reset and idle: hold `rstz`=0, then release with `en`=0 → all outputs 0, `state`=0 for 20 cycles.
- Full charge, ch0:
  - Config: vcutoff=100, vtarget=188, iend=10, tmin=20, tmax=200, tbat=80, tlimit=0.
  - Stimulus: vbat=60, `en`=1.
  - Expect TC one cycle later. Raise vbat to 120 → CC. Raise vbat to 190 → CV. Drop ibat 50→9 → DONE, `done`=1.
  - Ch1 with `en`=0 stays IDLE throughout.
- Timeout, ch0: tlimit=3, held in TC.
  - FAULT after 3 ticks: about 12 cycles, ±PRESC.
  - `fault` stays 1 while `en`=1. Lower `en` → IDLE one cycle later.
  - Same setup with the channel held in CV → DONE instead of FAULT.
- Temperature: in CC, set tbat=210 → FAULT next cycle and `cc`=0. Restoring tbat=80 does not leave FAULT.
- Recharge, ch0: vpreset=170.
  - From DONE, vbat=175 → stays DONE.
  - vbat=160 → CC (entry rule). vbat=90 → TC.
- Asynchronous reset mid-CV: pulse `rstz` low between clock edges → `cv`/`pwr_en` fall before the next edge; the channel restarts from IDLE.
